// File: rtl/johnson_seq_pkg.sv
// Shared types and Johnson-code helpers for the johnson_seq_ctrl block.
// Helpers work on a zero-extended JC_MAX_N-bit phase so one package serves any N <= JC_MAX_N.
package johnson_seq_pkg;

  localparam int JC_MAX_N  = 16;
  localparam int JC_STRB_W = 2 * JC_MAX_N;
  localparam logic [JC_MAX_N-1:0] JC_ONES = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } jc_state_e;

  // Phase index: with phase[0] set (or phase zero) the code is a low run of ones,
  // otherwise it is a high run and the index counts back from 2N.
  function automatic logic [JC_STRB_W-1:0] jc_decode(input logic [JC_MAX_N-1:0] ph,
                                                     input int n);
    int ones;
    logic [JC_MAX_N-1:0] sh;
    ones = 0;
    sh   = ph;
    for (int i = 0; i < JC_MAX_N; i++) begin
      if (i < n && sh[0]) ones++;
      sh = sh >> 1;
    end
    if (ph[0] || ones == 0) return JC_STRB_W'(1) << ones;
    return JC_STRB_W'(1) << (2 * n - ones);
  endfunction

  // True when ph matches one of the 2n codes of an n-stage Johnson counter.
  function automatic logic jc_legal(input logic [JC_MAX_N-1:0] ph, input int n);
    logic [JC_MAX_N-1:0] mask;
    logic [JC_MAX_N-1:0] code;
    logic ok;
    mask = ~(JC_ONES << n);
    ok   = 1'b0;
    for (int k = 0; k < 2 * JC_MAX_N; k++) begin
      if (k < 2 * n) begin
        code = (k <= n) ? ~(JC_ONES << k) : (mask & (JC_ONES << (k - n)));
        if (ph == code) ok = 1'b1;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/johnson_seq_ctrl_core.sv
// N-bit Johnson register with synchronous clear and advance enable.
// wrap flags the edge on which 1000..0 rolls over to all zeros.
module johnson_core
  import johnson_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         adv,
  output logic [N-1:0] phase,
  output logic         wrap
);

  localparam logic [N-1:0] WRAP_CODE = {1'b1, {(N-1){1'b0}}};

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      phase <= '0;
    end else if (adv) begin
      phase <= {phase[N-2:0], ~phase[N-1]};
    end
  end

  assign wrap = adv && (phase == WRAP_CODE);

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Start/busy/done sequencer around an N-stage Johnson counter (2N phases per revolution).
// Optional illegal-code recovery and sticky err are enabled with `define JSEQ_SELF_CORRECT_EN.
module johnson_seq_ctrl
  import johnson_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cont,
  input  logic [CNT_W-1:0] n_rev,
  output logic [N-1:0]     phase,
  output logic [2*N-1:0]   phase_strb,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rev_cnt,
  output logic             err
);

  jc_state_e            state;
  logic [CNT_W-1:0]     target;
  logic                 cont_q;
  logic                 stop_pending;
  logic                 core_clr;
  logic                 core_adv;
  logic                 wrap;
  logic                 run_end;
  logic                 illegal;
  logic [JC_MAX_N-1:0]  phase_ext;
  logic [JC_STRB_W-1:0] strb_full;

  assign phase_ext = JC_MAX_N'(phase);

`ifdef JSEQ_SELF_CORRECT_EN
  assign illegal = !jc_legal(phase_ext, N);

  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (illegal) begin
      err <= 1'b1;
    end
  end
`else
  assign illegal = 1'b0;
  assign err     = 1'b0;
`endif

  // Phase is held at zero outside RUN; an illegal code is also flushed to zero.
  assign core_adv = (state == RUN);
  assign core_clr = (state != RUN) || illegal;

  johnson_core #(.N(N)) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (core_clr),
    .adv   (core_adv),
    .phase (phase),
    .wrap  (wrap)
  );

  // A stop seen on the boundary cycle itself ends the revolution in progress.
  assign run_end = stop || stop_pending ||
                   (!cont_q && ((rev_cnt + CNT_W'(1)) == target));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      rev_cnt      <= '0;
      target       <= '0;
      cont_q       <= 1'b0;
      stop_pending <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            target       <= (n_rev == '0) ? CNT_W'(1) : n_rev;
            cont_q       <= cont;
            rev_cnt      <= '0;
            stop_pending <= 1'b0;
            busy         <= 1'b1;
            state        <= RUN;
          end
        end
        RUN: begin
          if (stop) stop_pending <= 1'b1;
          if (wrap) begin
            rev_cnt <= rev_cnt + CNT_W'(1);
            if (run_end) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
      // Illegal-code recovery wins over the normal transition; wrap never fires on it.
      if (illegal) begin
        busy  <= 1'b0;
        done  <= 1'b1;
        state <= DONE;
      end
    end
  end

  assign strb_full  = jc_decode(phase_ext, N);
  assign phase_strb = busy ? strb_full[2*N-1:0] : '0;

  a_strb_in_range: assert property (@(posedge clk) disable iff (reset)
    (strb_full >> (2 * N)) == '0);

  a_done_single: assert property (@(posedge clk) disable iff (reset)
    done |=> !done);

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed self-checking bench for johnson_seq_ctrl (N=4, CNT_W=8).
module tb_johnson_seq_ctrl;

  localparam int N     = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             cont;
  logic [CNT_W-1:0] n_rev;
  logic [N-1:0]     phase;
  logic [2*N-1:0]   phase_strb;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] rev_cnt;
  logic             err;

  int errors = 0;
  int checks = 0;

  logic [N-1:0] exp_ph [8];

  johnson_seq_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .cont       (cont),
    .n_rev      (n_rev),
    .phase      (phase),
    .phase_strb (phase_strb),
    .busy       (busy),
    .done       (done),
    .rev_cnt    (rev_cnt),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; stop = 1'b0; cont = 1'b0; n_rev = 8'd1;
    repeat (3) tick();
    checks++; if (phase !== 4'b0000) begin errors++; $display("FAIL reset_phase: got %b want 0000", phase); end
    checks++; if (phase_strb !== 8'h00) begin errors++; $display("FAIL reset_strb: got %b want 00000000", phase_strb); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (rev_cnt !== 8'd0) begin errors++; $display("FAIL reset_rev_cnt: got %0d want 0", rev_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    reset = 1'b0; start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored: busy got %b want 0", busy); end
  endtask

  task automatic test_single_shot;
    logic [2*N-1:0] e_strb;
    n_rev = 8'd2; cont = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      e_strb = (2*N)'(1) << (i % 8);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ss_busy[%0d]: got %b want 1", i, busy); end
      checks++; if (phase !== exp_ph[i % 8]) begin errors++; $display("FAIL ss_phase[%0d]: got %b want %b", i, phase, exp_ph[i % 8]); end
      checks++; if (phase_strb !== e_strb) begin errors++; $display("FAIL ss_strb[%0d]: got %b want %b", i, phase_strb, e_strb); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ss_done: got %b want 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ss_busy_end: got %b want 0", busy); end
    checks++; if (phase !== 4'b0000) begin errors++; $display("FAIL ss_phase_end: got %b want 0000", phase); end
    checks++; if (phase_strb !== 8'h00) begin errors++; $display("FAIL ss_strb_end: got %b want 00000000", phase_strb); end
    checks++; if (rev_cnt !== 8'd2) begin errors++; $display("FAIL ss_rev_cnt: got %0d want 2", rev_cnt); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL ss_done_pulse: got %b want 0", done); end
    checks++; if (rev_cnt !== 8'd2) begin errors++; $display("FAIL ss_rev_hold: got %0d want 2", rev_cnt); end
  endtask

  task automatic test_nrev_zero;
    n_rev = 8'd0; cont = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      start = (i == 3);
      checks++; if (phase !== exp_ph[i]) begin errors++; $display("FAIL nz_phase[%0d]: got %b want %b", i, phase, exp_ph[i]); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL nz_done: got %b want 1", done); end
    checks++; if (rev_cnt !== 8'd1) begin errors++; $display("FAIL nz_rev_cnt: got %0d want 1", rev_cnt); end
    start = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nz_start_in_done: busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL nz_done_pulse: got %b want 0", done); end
    start = 1'b0;
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nz_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_continuous;
    n_rev = 8'd1; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 24; i++) begin
      stop = (i == 19);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ct_busy[%0d]: got %b want 1", i, busy); end
      checks++; if (phase !== exp_ph[i % 8]) begin errors++; $display("FAIL ct_phase[%0d]: got %b want %b", i, phase, exp_ph[i % 8]); end
      if (i == 8) begin
        checks++; if (rev_cnt !== 8'd1) begin errors++; $display("FAIL ct_rev1: got %0d want 1", rev_cnt); end
      end
      if (i == 16) begin
        checks++; if (rev_cnt !== 8'd2) begin errors++; $display("FAIL ct_rev2: got %0d want 2", rev_cnt); end
      end
      tick();
    end
    stop = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ct_done: got %b want 1", done); end
    checks++; if (rev_cnt !== 8'd3) begin errors++; $display("FAIL ct_rev_cnt: got %0d want 3", rev_cnt); end
    checks++; if (phase !== 4'b0000) begin errors++; $display("FAIL ct_phase_end: got %b want 0000", phase); end
    tick();
  endtask

  task automatic test_stop_boundary;
    n_rev = 8'd5; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      stop = (i == 7);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sb_busy[%0d]: got %b want 1", i, busy); end
      tick();
    end
    stop = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sb_done: got %b want 1", done); end
    checks++; if (rev_cnt !== 8'd1) begin errors++; $display("FAIL sb_rev_cnt: got %0d want 1", rev_cnt); end
    tick();
  endtask

  task automatic test_reset_midrun;
    n_rev = 8'd3; cont = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (13) tick();
    checks++; if (phase !== 4'b1110) begin errors++; $display("FAIL mr_phase_pre: got %b want 1110", phase); end
    checks++; if (rev_cnt !== 8'd1) begin errors++; $display("FAIL mr_rev_pre: got %0d want 1", rev_cnt); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (phase !== 4'b0000) begin errors++; $display("FAIL mr_phase: got %b want 0000", phase); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mr_done: got %b want 0", done); end
    checks++; if (rev_cnt !== 8'd0) begin errors++; $display("FAIL mr_rev_cnt: got %0d want 0", rev_cnt); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mr_no_done: got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_idle: busy got %b want 0", busy); end
  endtask

  task automatic test_err;
`ifdef JSEQ_SELF_CORRECT_EN
    n_rev = 8'd1; cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    force dut.u_core.phase = 4'b0101;
    #1;
    release dut.u_core.phase;
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sc_err: got %b want 1", err); end
    checks++; if (phase !== 4'b0000) begin errors++; $display("FAIL sc_phase: got %b want 0000", phase); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL sc_done: got %b want 1", done); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL sc_err_sticky: got %b want 1", err); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL sc_done_pulse: got %b want 0", done); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL sc_err_reset: got %b want 0", err); end
`else
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_tied: got %b want 0", err); end
`endif
  endtask

  initial begin
    exp_ph[0] = 4'b0000; exp_ph[1] = 4'b0001; exp_ph[2] = 4'b0011; exp_ph[3] = 4'b0111;
    exp_ph[4] = 4'b1111; exp_ph[5] = 4'b1110; exp_ph[6] = 4'b1100; exp_ph[7] = 4'b1000;
    reset = 1'b1; start = 1'b0; stop = 1'b0; cont = 1'b0; n_rev = '0;
    @(negedge clk);
    test_reset();
    test_single_shot();
    test_nrev_zero();
    test_continuous();
    test_stop_boundary();
    test_reset_midrun();
    test_err();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/johnson_seq_ctrl.md
Name: johnson_seq_ctrl

Overview:
Controller that sequences an embedded N-stage Johnson counter as a 2N-phase timing generator. Run it single-shot for a programmed number of revolutions, or continuously. It provides a start/busy/done handshake, graceful stop at a revolution boundary, and one-hot phase strobes for downstream datapath enables. It sits between the control/CSR logic and any block that needs a rotating phase schedule.

Parameters:
N, 4, Johnson stages; 2N phases per revolution; N >= 2
CNT_W, 8, width of revolution target and revolution counter

Ports:
clk  in  1  clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
start  in  1  request a run; sampled only in IDLE
stop  in  1  request graceful stop; sampled only in RUN
cont  in  1  1 = continuous mode; latched on start acceptance
n_rev  in  CNT_W  single-shot revolution target, latched on start; 0 treated as 1
phase  out  N  current Johnson state
phase_strb  out  2N  one-hot phase decode; all zero when busy=0
busy  out  1  high in RUN
done  out  1  one-cycle pulse in DONE
rev_cnt  out  CNT_W  completed revolutions in the current or last run
err  out  1  sticky illegal-state flag (see Optional Feature)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset: FSM=IDLE; phase=0; phase_strb=0; busy=0; done=0; rev_cnt=0; err=0; latched target/cont/stop_pending=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: phase is held at 0. If start=1: latch n_rev (0->1) and cont, clear rev_cnt and stop_pending, go to RUN.
- RUN: busy=1. phase advances every cycle as {phase[N-2:0], ~phase[N-1]}.
  - Phase index k: for k<=N, the low k bits are ones; for k>N, the top 2N-k bits are ones.
  - phase_strb[k]=1 for the current index.
- Revolution boundary: the edge where phase = 1 followed by N-1 zeros wraps to 0. On that edge rev_cnt increments (modulo 2^CNT_W).
  - Go to DONE if (!cont and rev_cnt+1 == target) or stop_pending. Otherwise stay in RUN.
- stop in RUN sets stop_pending. The run ends at the next boundary, so phase always ends at 0. A stop on the boundary cycle itself ends that revolution.
- DONE: phase=0, busy=0, done=1 for exactly one cycle, then IDLE. start is ignored in DONE and RUN (no queuing).
- Latency, single-shot, n_rev=1, N=4:
  - start at cycle t; busy t+1..t+8 with strb index 0..7; done at t+9; IDLE at t+10.
  - Total 2N*target+1 cycles from start to done.
- In IDLE, start and stop in the same cycle: stop is ignored.
- rev_cnt holds its final value after done until the next accepted start.
- reset asserted in any state, mid-run included, overrides everything and restores reset values on the next edge.

Optional Feature:
Macro JSEQ_SELF_CORRECT_EN.
- Defined: every cycle the block checks phase against the 2N legal codes. On an illegal code:
  - err set (sticky until reset).
  - Next edge: phase forced to 0 and FSM to DONE (done pulse); rev_cnt not incremented.
- Undefined: no check; err tied to 0; illegal codes propagate per the shift rule.

Decomposition:
- Package johnson_seq_pkg holds:
  - FSM state enum typedef (IDLE/RUN/DONE).
  - Function jc_decode(phase) returning the one-hot 2N-bit index.
  - Function jc_legal(phase).
- One sub-module: johnson_core. It is the N-bit Johnson register with synchronous clear and advance-enable inputs, plus the wrap-edge flag output.
- The FSM, latches and rev_cnt stay in johnson_seq_ctrl.

Test Plan:
- Reset (N=4): hold reset 3 cycles -> all outputs 0, FSM IDLE; start asserted during reset is ignored.
- Single-shot: n_rev=2, cont=0, start pulse at t -> phase sequence 0000,0001,0011,0111,1111,1110,1100,1000 twice; done at t+17; rev_cnt=2.
- n_rev=0 -> behaves as 1: done at t+9, rev_cnt=1; start re-pulsed during RUN/DONE -> no effect.
- Continuous: cont=1, stop pulsed at phase=0111 in revolution 3 -> run continues to the 1000->0000 wrap; done next cycle; rev_cnt=3; phase=0.
- Reset mid-run at phase=1110 -> next cycle phase=0, busy=0, no done pulse, rev_cnt=0.
- With JSEQ_SELF_CORRECT_EN: force phase=0101 in RUN -> err=1, next cycle phase=0000 and done=1; err stays 1 until reset. Without the macro: err stays 0.
